tt_sweep_collector: RTL and testbench
=====================================

TT_SWEEP_COLLECTOR -- requirements
Module: tt_sweep_collector

Interface
REQ-001 SHALL have parameter PIPE, default 0, range 0..3: cycles between x0..x6 changing and the matching f_in being valid.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request one exhaustive sweep; sampled only in IDLE.
REQ-005 SHALL have ports x0..x6  output  1 each  stimulus to the 7-input function under test; x0 = LSB of index.
REQ-006 SHALL have port f_in  input  1  function-under-test output for the stimulus presented PIPE cycles earlier.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port tt_valid  output  1  truth table available.
REQ-009 SHALL have port tt_ready  input  1  consumer accepts truth table.
REQ-010 SHALL have port tt_data  output  128  truth table; bit i = f(index i), index i = {x6,x5,x4,x3,x2,x1,x0}.
REQ-011 SHALL have port ones_count  output  8  number of set bits in tt_data, range 0..128.

Function
REQ-012 SHALL implement states IDLE, SWEEP, DRAIN and HOLD.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL clear tt_data and ones_count, set index=0, and enter SWEEP.
REQ-014 In SWEEP, x0..x6 SHALL equal index, and index SHALL increment by 1 each cycle from 0 to 127 with no skips or repeats.
REQ-015 After index=127 is presented, the block SHALL enter DRAIN for PIPE cycles; with PIPE=0 it SHALL go directly to HOLD.
REQ-016 The f_in value for index k SHALL be captured at edge E(k+1+PIPE) into tt_data[k]; ones_count SHALL increment by 1 when the captured f_in=1.
REQ-017 Capture SHALL use a PIPE-deep delayed index/valid pipeline, never the current index.
REQ-018 tt_valid SHALL rise at edge E(128+PIPE) and the block SHALL be in HOLD; tt_data and ones_count SHALL be final at that point.
REQ-019 In HOLD, tt_valid SHALL stay high and tt_data/ones_count SHALL stay stable until an edge with tt_valid&tt_ready.
REQ-020 When that handshake occurs, the block SHALL return to IDLE and tt_valid SHALL be low in the next cycle.
REQ-021 After the handshake, tt_data and ones_count SHALL retain their values until the next accepted start.
REQ-022 start SHALL be ignored outside IDLE, and start in the handshake cycle SHALL NOT be accepted; it is accepted only from the following IDLE cycle.
REQ-023 x0..x6 SHALL be 0 in IDLE, DRAIN and HOLD.
REQ-024 ones_count SHALL saturate-free count to exactly 128 for an all-ones function; 8 bits SHALL be used so no wrap occurs.
REQ-025 tt_ready while tt_valid=0 SHALL have no effect.

Reset
REQ-026 rst=1 at any edge, including mid-SWEEP, mid-DRAIN or in HOLD, SHALL force IDLE and set index=0, x0..x6=0, busy=0, tt_valid=0, tt_data=0 and ones_count=0.
REQ-027 rst SHALL override start and tt_ready in the same cycle.
REQ-028 In-flight captures SHALL be discarded on reset, and no partial table SHALL ever be presented.

Verification
REQ-029 PIPE=0, f_in = majority(x0,x1,x2) combinational, start pulse -> tt_valid at E128, tt_data={16{8'hE8}}, ones_count=64.
REQ-030 PIPE=0, f_in tied 0 and then tied 1 (two sweeps) -> tt_data=0 with ones_count=0, then tt_data=all ones with ones_count=128.
REQ-031 PIPE=2, f_in = x0 registered twice -> tt_data={64{2'b10}}, ones_count=64, tt_valid at E130; an undelayed model mismatch SHALL be flagged.
REQ-032 Backpressure: tt_ready low for 10 cycles after tt_valid -> tt_data/ones_count constant, busy=1; tt_ready pulse -> IDLE, tt_valid=0 next cycle.
REQ-033 rst at index=60 -> next cycle all outputs 0/IDLE; new start -> full correct 128-entry sweep from index 0.
REQ-034 start held high continuously -> back-to-back sweeps separated by at least one IDLE cycle after each handshake; start pulses during SWEEP/HOLD ignored.

Source files
------------

// File: rtl/tt_sweep_collector.sv
// tt_sweep_collector: exhaustive 7-input truth-table sweep with pipelined capture and valid/ready hold
module tt_sweep_collector #(
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         x0,
  output logic         x1,
  output logic         x2,
  output logic         x3,
  output logic         x4,
  output logic         x5,
  output logic         x6,
  input  logic         f_in,
  output logic         busy,
  output logic         tt_valid,
  input  logic         tt_ready,
  output logic [127:0] tt_data,
  output logic [7:0]   ones_count
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;
  localparam int D = PIPE > 0 ? PIPE : 1;
  state_t     state;
  logic [6:0] index;
  logic [1:0] dc;
  logic [D-1:0] v_r;
  logic [6:0] i_r [D];
  logic       cap_v;
  logic [6:0] cap_i;
  assign {x6, x5, x4, x3, x2, x1, x0} = state == SWEEP ? index : 7'd0;
  assign busy = state != IDLE;
  assign tt_valid = state == HOLD;
  // capture tap: the index presented PIPE cycles ago, never the live one
  always_comb begin
    cap_v = PIPE == 0 ? state == SWEEP : v_r[D-1];
    cap_i = PIPE == 0 ? index : i_r[D-1];
  end
  // delay line tracking which index f_in currently belongs to; reset drops in-flight entries
  always_ff @(posedge clk) begin
    for (int j = 0; j < D; j++) begin
      v_r[j] <= rst ? 1'b0 : (j == 0 ? state == SWEEP : v_r[j == 0 ? 0 : j-1]);
      i_r[j] <= j == 0 ? index : i_r[j == 0 ? 0 : j-1];
    end
  end
  // sweep sequencing, table capture and result hold until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= 7'd0;
      dc         <= 2'd0;
      tt_data    <= '0;
      ones_count <= 8'd0;
    end else begin
      if (cap_v) begin
        tt_data[cap_i] <= f_in;
        ones_count     <= ones_count + {7'd0, f_in};
      end
      case (state)
        IDLE: if (start) begin
          state      <= SWEEP;
          index      <= 7'd0;
          tt_data    <= '0;
          ones_count <= 8'd0;
        end
        SWEEP: begin
          index <= index + 7'd1;
          if (index == 7'd127) begin
            state <= PIPE == 0 ? HOLD : DRAIN;
            dc    <= 2'd0;
          end
        end
        DRAIN: begin
          dc <= dc + 2'd1;
          if (dc == 2'(PIPE - 1)) state <= HOLD;
        end
        default: if (tt_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sweep_collector.sv
// tb_tt_sweep_collector: directed checks of sweep, capture latency, backpressure and reset for PIPE=0 and PIPE=2
module tb_tt_sweep_collector;
  logic clk = 1'b0;
  logic rst, start0, start2, ready0, ready2;
  logic [1:0] mode;
  logic a0, a1, a2, a3, a4, a5, a6, b0, b1, b2, b3, b4, b5, b6;
  logic f0, f2, r1, r2;
  logic busy0, valid0, busy2, valid2;
  logic [127:0] data0, data2;
  logic [7:0] ones0, ones2;
  logic [6:0] xv0, xv2;
  int n_assert = 0;
  int n_fail = 0;
  int cnt;
  always #5 clk = ~clk;
  assign xv0 = {a6, a5, a4, a3, a2, a1, a0};
  assign xv2 = {b6, b5, b4, b3, b2, b1, b0};
  assign f0 = mode == 2'd0 ? (a0 & a1) | (a0 & a2) | (a1 & a2) : mode == 2'd2;
  always_ff @(posedge clk) begin
    r1 <= b0;
    r2 <= r1;
  end
  assign f2 = r2;
  tt_sweep_collector #(.PIPE(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .x0(a0), .x1(a1), .x2(a2), .x3(a3), .x4(a4), .x5(a5), .x6(a6),
    .f_in(f0), .busy(busy0), .tt_valid(valid0), .tt_ready(ready0),
    .tt_data(data0), .ones_count(ones0));
  tt_sweep_collector #(.PIPE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .x0(b0), .x1(b1), .x2(b2), .x3(b3), .x4(b4), .x5(b5), .x6(b6),
    .f_in(f2), .busy(busy2), .tt_valid(valid2), .tt_ready(ready2),
    .tt_data(data2), .ones_count(ones2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // cycles from the start edge until tt_valid, bounded
  task automatic wait_valid(input bit which, output int n);
    n = 0;
    while (!(which ? valid2 : valid0) && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic hs0();
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
  endtask
  task automatic sweep0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_valid(1'b0, cnt);
  endtask
  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; ready0 = 1'b0; ready2 = 1'b0; mode = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_ones", ones0, 0);
    chk("rst_x", xv0, 0);
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    chk("ready_idle_no_effect", {busy0, valid0}, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("sweep_busy", busy0, 1);
    chk("sweep_x_idx0", xv0, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("sweep_x_idx5", xv0, 5);
    cnt = 5;
    while (!valid0 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("maj_latency", cnt, 128);
    chk("maj_data", data0, {16{8'hE8}});
    chk("maj_ones", ones0, 64);
    chk("hold_x", xv0, 0);
    for (int i = 0; i < 10; i++) begin
      start0 = i == 3;
      tick();
    end
    start0 = 1'b0;
    chk("bp_data", data0, {16{8'hE8}});
    chk("bp_ones", ones0, 64);
    chk("bp_busy_valid", {busy0, valid0}, 2'b11);
    hs0();
    chk("hs_valid_low", valid0, 0);
    chk("hs_idle", busy0, 0);
    chk("retain_data", data0, {16{8'hE8}});
    chk("retain_ones", ones0, 64);
    mode = 2'd1;
    sweep0();
    chk("zero_latency", cnt, 128);
    chk("zero_data", data0, 0);
    chk("zero_ones", ones0, 0);
    hs0();
    mode = 2'd2;
    sweep0();
    chk("ones_data", data0, {128{1'b1}});
    chk("ones_count128", ones0, 128);
    hs0();
    mode = 2'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cnt = 0;
    while (xv0 != 7'd60 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("reach_idx60", cnt, 60);
    rst = 1'b1;
    start0 = 1'b1;
    tick();
    rst = 1'b0;
    start0 = 1'b0;
    chk("midrst_busy", busy0, 0);
    chk("midrst_valid", valid0, 0);
    chk("midrst_x", xv0, 0);
    chk("midrst_data", data0, 0);
    chk("midrst_ones", ones0, 0);
    sweep0();
    chk("resweep_latency", cnt, 128);
    chk("resweep_data", data0, {16{8'hE8}});
    chk("resweep_ones", ones0, 64);
    start0 = 1'b1;
    hs0();
    chk("held_start_idle_gap", busy0, 0);
    tick();
    chk("held_start_restart", busy0, 1);
    chk("held_start_x0", xv0, 0);
    wait_valid(1'b0, cnt);
    chk("held_start_no_restart", cnt, 128);
    chk("held_start_data", data0, {16{8'hE8}});
    start0 = 1'b0;
    hs0();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_valid(1'b1, cnt);
    chk("p2_latency", cnt, 130);
    chk("p2_data", data2, {64{2'b10}});
    chk("p2_ones", ones2, 64);
    chk("p2_x", xv2, 0);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    chk("p2_hs", {busy2, valid2}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
